// File: rtl/i2s_pkg.sv
// Shared I2S constants: default geometry, frame length helper and LRCK channel encoding.
package i2s_pkg;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_SLOT_BITS = 32;
  localparam int DEF_BCK_DIV   = 2;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  function automatic int frame_bits(input int slot_bits);
    return 2 * slot_bits;
  endfunction
endpackage

// File: rtl/i2s_bck_gen.sv
// Bit clock divider: toggles o_bck every BCK_DIV system clocks and flags the
// cycle in which o_bck is registered 1->0 so downstream state moves on the falling edge.
module i2s_bck_gen
  import i2s_pkg::*;
#(
  parameter int BCK_DIV = DEF_BCK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_bck,
  output logic o_fall
);
  localparam int CW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc     = (cnt == CW'(BCK_DIV - 1));
  assign o_fall = tc && o_bck;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt   <= '0;
      o_bck <= 1'b0;
    end else if (tc) begin
      cnt   <= '0;
      o_bck <= ~o_bck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry sample-pair buffer, per-frame load, MSB-first shifter.
// Define I2S_TX_REPEAT_ON_UNDERRUN_EN to repeat the last pair on underrun instead of sending zeros.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int BCK_DIV   = DEF_BCK_DIV
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_left,
  input  logic [WIDTH-1:0] i_right,
  output logic             o_bck,
  output logic             o_lrck,
  output logic             o_sdata,
  output logic             o_underrun
);
  localparam int FRAME = frame_bits(SLOT_BITS);
  localparam int BW    = $clog2(FRAME);

  logic             fall;
  logic             wrap;
  logic             accept;
  logic [BW-1:0]    b;
  logic [BW-1:0]    b_next;
  logic             buf_full;
  logic [WIDTH-1:0] buf_l, buf_r;
  logic [WIDTH-1:0] frm_l, frm_r;
  logic             lr_next;
  logic             sd_next;
  int               p;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] sh;

  i2s_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_bck  (o_bck),
    .o_fall (fall)
  );

  assign wrap    = (b == BW'(FRAME - 1));
  assign b_next  = wrap ? '0 : b + 1'b1;
  assign accept  = i_valid && !buf_full;
  assign o_ready = !buf_full;

  // Output bit for the position the counter moves to on this fall; slot bit 0 is the I2S delay bit.
  always_comb begin
    lr_next = (int'(b_next) >= SLOT_BITS) ? LR_RIGHT : LR_LEFT;
    p       = (lr_next == LR_RIGHT) ? int'(b_next) - SLOT_BITS : int'(b_next);
    word    = (lr_next == LR_RIGHT) ? frm_r : frm_l;
    sh      = '0;
    sd_next = 1'b0;
    if (p >= 1 && p <= WIDTH) begin
      sh      = word >> (WIDTH - p);
      sd_next = sh[0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      b          <= BW'(FRAME - 1);
      buf_full   <= 1'b0;
      buf_l      <= '0;
      buf_r      <= '0;
      frm_l      <= '0;
      frm_r      <= '0;
      o_lrck     <= LR_RIGHT;
      o_sdata    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_underrun <= 1'b0;
      if (accept) begin
        buf_full <= 1'b1;
        buf_l    <= i_left;
        buf_r    <= i_right;
      end
      if (fall) begin
        b       <= b_next;
        o_lrck  <= lr_next;
        o_sdata <= sd_next;
        if (wrap) begin
          if (buf_full) begin
            frm_l    <= buf_l;
            frm_r    <= buf_r;
            buf_full <= 1'b0;
          end else begin
            o_underrun <= 1'b1;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            // frame registers hold: the previous pair is sent again
`else
            frm_l <= '0;
            frm_r <= '0;
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: per-cycle comparison against a frame/bit-index reference model.
module tb_i2s_tx;
  localparam int WIDTH     = 16;
  localparam int SLOT_BITS = 32;
  localparam int BCK_DIV   = 2;
  localparam int FRAME     = 2 * SLOT_BITS;
  localparam int FCLK      = FRAME * 2 * BCK_DIV;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_valid = 1'b0;
  logic [WIDTH-1:0] i_left = '0;
  logic [WIDTH-1:0] i_right = '0;
  logic             o_ready, o_bck, o_lrck, o_sdata, o_underrun;

  int checks = 0;
  int failures = 0;

  // reference model state
  int               k;
  logic             q_full;
  logic [WIDTH-1:0] q_l, q_r, fr_l, fr_r;
  logic             e_bck, e_lrck, e_sdata, e_und;

  always #5 clk = ~clk;

  i2s_tx #(.WIDTH(WIDTH), .SLOT_BITS(SLOT_BITS), .BCK_DIV(BCK_DIV)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_left     (i_left),
    .i_right    (i_right),
    .o_bck      (o_bck),
    .o_lrck     (o_lrck),
    .o_sdata    (o_sdata),
    .o_underrun (o_underrun)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; q_full = 0; q_l = '0; q_r = '0; fr_l = '0; fr_r = '0;
    e_bck = 0; e_lrck = 1; e_sdata = 0; e_und = 0;
  endtask

  // Edge k after reset release: BCK falls on edges 4n+3, fall n sits at bit n mod 64 of frame n/64.
  task automatic model_step(input logic v, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    logic             acc;
    int               n, bi, p;
    logic [WIDTH-1:0] w;
    acc   = v && !q_full;
    e_und = 0;
    e_bck = ((k + 1) / BCK_DIV) % 2;
    if ((k + 1) % (2 * BCK_DIV) == 0) begin
      n  = (k + 1) / (2 * BCK_DIV) - 1;
      bi = n % FRAME;
      if (bi == 0) begin
        if (q_full) begin
          fr_l = q_l; fr_r = q_r; q_full = 0;
        end else begin
          e_und = 1;
`ifndef I2S_TX_REPEAT_ON_UNDERRUN_EN
          fr_l = '0; fr_r = '0;
`endif
        end
      end
      e_lrck  = (bi >= SLOT_BITS);
      p       = bi % SLOT_BITS;
      w       = e_lrck ? fr_r : fr_l;
      e_sdata = (p >= 1 && p <= WIDTH) ? w[4'(WIDTH - p)] : 1'b0;
    end
    if (acc) begin
      q_full = 1; q_l = l; q_r = r;
    end
    k++;
  endtask

  task automatic tick(input logic rst, input logic v, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    i_rst = rst; i_valid = v; i_left = l; i_right = r;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(v, l, r);
    #1;
    chk("bck", 16'(o_bck), 16'(e_bck));
    chk("lrck", 16'(o_lrck), 16'(e_lrck));
    chk("sdata", 16'(o_sdata), 16'(e_sdata));
    chk("underrun", 16'(o_underrun), 16'(e_und));
    chk("ready", 16'(o_ready), 16'(!q_full));
  endtask

  task automatic idle_until(input int target);
    while (k < target) tick(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int target;
    model_reset();
    // reset state
    repeat (3) tick(1'b1, 1'b0, '0, '0);

    // idle first frame (underrun, zeros), then one known pair, then starvation
    idle_until(20);
    tick(1'b0, 1'b1, 16'hA5C3, 16'h8001);
    idle_until(3 * FCLK + 10);

    // back-to-back with valid held high and random data
    repeat (4 * FCLK) tick(1'b0, 1'b1, 16'($urandom), 16'($urandom));

    // drain, then accept exactly on a frame-load edge with the buffer empty
    target = ((k / FCLK) + 2) * FCLK + 2 * BCK_DIV - 1;
    idle_until(target);
    tick(1'b0, 1'b1, 16'h1234, 16'hFEDC);
    idle_until(k + 2 * FCLK);

    // sparse random traffic
    repeat (3 * FCLK) begin
      if ($urandom_range(0, 99) == 0) tick(1'b0, 1'b1, 16'($urandom), 16'($urandom));
      else tick(1'b0, 1'b0, '0, '0);
    end

    // reset in the middle of the right slot, then restart with an accept in cycle 0
    tick(1'b0, 1'b1, 16'h5A5A, 16'hC33C);
    target = ((k / FCLK) + 1) * FCLK + 2 * BCK_DIV - 1 + 2 * BCK_DIV * 40;
    idle_until(target);
    repeat (2) tick(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    tick(1'b0, 1'b1, 16'hA5C3, 16'h8001);
    idle_until(2 * FCLK + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serialises stereo PCM samples into a standard I2S stream (BCK, LRCK, SDATA) for the output DAC/codec side of the AD1868-to-I2S converter.
- Sits directly downstream of the per-bit capture/holding stage and its word assembler. It consumes reconstructed left/right words through a valid/ready handshake.
- BCK is generated internally from the system clock by an integer divider.

Parameters:
- WIDTH, 16, sample word width per channel; must be <= SLOT_BITS-1.
- SLOT_BITS, 32, BCK periods per channel slot; a frame is 2*SLOT_BITS bits.
- BCK_DIV, 2, system clocks per BCK half-period; must be >= 1.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream sample pair valid.
- o_ready  out  1  one-entry holding buffer empty.
- i_left  in  WIDTH  left sample, two's complement.
- i_right  in  WIDTH  right sample, two's complement.
- o_bck  out  1  I2S bit clock.
- o_lrck  out  1  word select: 0 = left, 1 = right.
- o_sdata  out  1  serial data, MSB first.
- o_underrun  out  1  one-cycle pulse when a frame starts with the buffer empty.

Behaviour:
- Reset values:
  - o_bck=0, o_lrck=1, o_sdata=0, o_ready=1, o_underrun=0.
  - Divider count=0, bit counter=2*SLOT_BITS-1, buffer empty, frame registers zero.
- Divider:
  - Counts 0..BCK_DIV-1. At terminal count it wraps to 0 and toggles o_bck.
  - A "fall" strobe is asserted in the cycle o_bck is registered 1->0.
  - BCK period = 2*BCK_DIV clocks.
- Bit counter b (0..2*SLOT_BITS-1):
  - Increments on each fall strobe, wrapping at 2*SLOT_BITS-1 -> 0.
  - o_lrck and o_sdata are registered in the same cycle as the fall, so they change only with BCK falling edges.
  - o_lrck = (b >= SLOT_BITS).
- Slot position p = b mod SLOT_BITS:
  - p = 0: o_sdata = 0. This is the I2S one-BCK delay after LRCK changes.
  - p = 1..WIDTH: o_sdata = word[WIDTH-p], MSB first.
  - p > WIDTH: o_sdata = 0.
  - The word is the left sample in the left slot and the right sample in the right slot.
- Handshake:
  - An accept occurs in the cycle where i_valid && o_ready. i_left and i_right are captured into the buffer, and o_ready drops the next cycle.
  - i_valid may be held high; input data are ignored while o_ready=0.
- Frame load, on the fall strobe where b wraps to 0:
  - Buffer full: the buffer is copied to the frame registers and marked empty; o_ready rises the next cycle.
  - Buffer empty: the frame registers are loaded with zeros and o_underrun pulses for exactly one cycle.
  - Accept and load in the same cycle: this is only possible with the buffer empty. The load takes the underrun path, and the accepted word fills the buffer for the next frame.
- First frame after reset:
  - The first fall strobe occurs 2*BCK_DIV clocks after reset deassertion. It wraps b to 0 and performs a load.
  - An accept in cycle 0 therefore appears in frame 0.
- Reset mid-frame aborts immediately. All state returns to reset values; no partial word completes.
- Steady-state throughput: one sample pair per 2*SLOT_BITS*2*BCK_DIV clocks.

Optional Feature:
- Macro: I2S_TX_REPEAT_ON_UNDERRUN_EN.
- Defined: on underrun the frame registers keep their previous contents, so the last sample pair is repeated; o_underrun still pulses.
- Undefined: on underrun the frame registers are loaded with zeros, as above.

Decomposition:
- Shared package i2s_pkg holds:
  - the default constants (WIDTH, SLOT_BITS, BCK_DIV);
  - the frame-length function 2*SLOT_BITS;
  - the LRCK channel encoding constants LR_LEFT=0, LR_RIGHT=1.
- One natural sub-module, i2s_bck_gen: the divider producing o_bck and the fall strobe. Buffer, counter and shifter stay in i2s_tx.

Test Plan (WIDTH=16, SLOT_BITS=32, BCK_DIV=2):
- Reset release, no input -> o_bck toggles every 2 clocks; first fall at clock 4 with o_lrck=0 and o_underrun high one cycle; o_sdata stays 0 for the whole frame.
- Accept L=16'hA5C3, R=16'h8001 in cycle 0 -> left slot: bit p=0 is 0, bits p=1..16 are A5C3 MSB first, p=17..31 are 0. Right slot: 8001 likewise, with o_lrck=1 exactly from the 33rd fall of the frame.
- Back-to-back accepts with i_valid held high -> o_ready rises one cycle after each frame load; the second pair follows 256 clocks later with no underrun pulse.
- Starve after one pair -> second frame has o_underrun pulse and all-zero data. With I2S_TX_REPEAT_ON_UNDERRUN_EN defined, the second frame repeats A5C3/8001.
- Accept coincident with a frame-load fall while empty -> o_underrun pulses, that frame is zero, and the accepted pair appears in the following frame.
- Assert i_rst mid right-slot -> next cycle all outputs equal reset values; after release, timing restarts exactly as in the first scenario.
